// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute controller for the course CPU datapath.
// It drives the PC register load and the IR/ACC load strobes. Every output is
// a flop, so PCload/PC_in stay stable across the falling edge on which the
// PC register samples.
module pc_sequencer #(
    parameter int          ADDR_W    = 4,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [7:0]        instr,
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic              zero,
    output logic              PCload,
    output logic [ADDR_W-1:0] PC_in,
    output logic              IRload,
    output logic              ACCload,
    output logic [1:0]        ALUop,
    output logic              halted,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JZ   = 4'h5;
    localparam logic [3:0] OP_JNZ  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            st_q, st_d;
    logic [3:0]        op_q, opnd_q;
    logic [ADDR_W-1:0] pc_q;
    logic              ss_q, ss_d;

    logic              pcl_d, irl_d, accl_d, hlt_d;
    logic [ADDR_W-1:0] pcin_d;
    logic [1:0]        alu_d;
    logic [ADDR_W-1:0] pc_inc, opnd_ext, tgt;

    assign state    = st_q;
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign opnd_ext = ADDR_W'(opnd_q);

    // Branch target resolution from the latched instruction and the live zero flag
    always_comb begin
        tgt = pc_inc;
        case (op_q)
            OP_JMP:  tgt = opnd_ext;
            OP_JZ:   tgt = zero  ? opnd_ext : pc_inc;
            OP_JNZ:  tgt = !zero ? opnd_ext : pc_inc;
            default: tgt = pc_inc;
        endcase
    end

    // Next state plus the output values that belong to that next state, so the
    // registered outputs line up with the state they describe
    always_comb begin
        st_d   = st_q;
        ss_d   = ss_q;
        pcl_d  = 1'b0;
        pcin_d = '0;
        irl_d  = 1'b0;
        accl_d = 1'b0;
        alu_d  = 2'b00;
        hlt_d  = 1'b0;
        case (st_q)
            S_INIT: begin
                // PCload doubles as the phase bit: first cycle pulses the
                // reset vector load, second cycle moves on to IDLE
                if (!PCload) begin
                    pcl_d  = 1'b1;
                    pcin_d = ADDR_W'(RESET_VEC);
                end else begin
                    st_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (run) begin
                    st_d  = S_FETCH;
                    ss_d  = 1'b0;
                    irl_d = 1'b1;
                end else if (step) begin
                    st_d  = S_FETCH;
                    ss_d  = 1'b1;
                    irl_d = 1'b1;
                end
            end
            S_FETCH: st_d = S_DECODE;
            S_DECODE: begin
                if (op_q == OP_HALT) begin
                    st_d  = S_HALT;
                    hlt_d = 1'b1;
                end else begin
                    st_d   = S_EXEC;
                    pcl_d  = 1'b1;
                    pcin_d = tgt;
                    case (op_q)
                        OP_LDI:  begin accl_d = 1'b1; alu_d = 2'b00; end
                        OP_ADD:  begin accl_d = 1'b1; alu_d = 2'b01; end
                        OP_SUB:  begin accl_d = 1'b1; alu_d = 2'b10; end
                        default: ;
                    endcase
                end
            end
            S_EXEC: begin
                ss_d = 1'b0;
                if (run && !ss_q) begin
                    st_d  = S_FETCH;
                    irl_d = 1'b1;
                end else begin
                    st_d = S_IDLE;
                end
            end
            S_HALT: hlt_d = 1'b1;
            default: st_d = S_INIT;
        endcase
    end

    // State, single-step flag and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= S_INIT;
            ss_q    <= 1'b0;
            PCload  <= 1'b0;
            PC_in   <= '0;
            IRload  <= 1'b0;
            ACCload <= 1'b0;
            ALUop   <= 2'b00;
            halted  <= 1'b0;
        end else begin
            st_q    <= st_d;
            ss_q    <= ss_d;
            PCload  <= pcl_d;
            PC_in   <= pcin_d;
            IRload  <= irl_d;
            ACCload <= accl_d;
            ALUop   <= alu_d;
            halted  <= hlt_d;
        end
    end

    // Capture the fetched instruction and its address while in FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            opnd_q <= '0;
            pc_q   <= '0;
        end else if (st_q == S_FETCH) begin
            op_q   <= instr[7:4];
            opnd_q <= instr[3:0];
            pc_q   <= pc_cur;
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/decode/execute controller that drives the 4-bit program-counter register and the instruction/accumulator load strobes of the course CPU datapath. It fetches from program memory addressed by the current PC, decodes a 4-bit opcode, and issues exactly one PC load per instruction: either increment or branch target. It supports free-run and single-step operation and a terminal HALT.

## Interface
- ADDR_W, 4, PC width in bits; sets the width of `pc_cur`, `PC_in` and the operand field.
- RESET_VEC, 0, PC value loaded during the INIT state after reset release.

Ports:
- clk  in  1  system clock; all controller state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- run  in  1  level input; when 1, instructions execute back-to-back.
- step  in  1  one-cycle pulse; sampled in IDLE only, and executes one instruction.
- instr  in  8  program memory data at address `pc_cur`: [7:4] opcode, [3:0] operand.
- pc_cur  in  ADDR_W  PC register output, fed back.
- zero  in  1  accumulator-is-zero flag.
- PCload  out  1  PC register load enable.
- PC_in  out  ADDR_W  next-PC value to the PC register.
- IRload  out  1  instruction register load strobe.
- ACCload  out  1  accumulator load strobe.
- ALUop  out  2  ALU select: 00 pass immediate, 01 add, 10 sub, 11 unused.
- halted  out  1  high while in HALT.
- state  out  3  current state encoding, for debug.

## Operation
- State encodings: INIT=0, IDLE=1, FETCH=2, DECODE=3, EXEC=4, HALT=5. Codes 6 and 7 go to INIT on the next edge.
- INIT:
  - Drives PCload=1 and PC_in=RESET_VEC for one cycle.
  - Then goes to IDLE.
- IDLE:
  - If run=1, go to FETCH.
  - Else if step=1, go to FETCH with the single-step flag set.
  - Else stay in IDLE.
  - When run and step are both 1, run wins and the single-step flag stays clear.
- FETCH:
  - IRload=1 for one cycle.
  - Latches opcode and operand from `instr`, and latches `pc_cur`.
  - Goes to DECODE.
- DECODE:
  - Computes the target and samples `zero`.
  - Opcode 0 (NOP), 1 (LDI), 2 (ADD), 3 (SUB): target = pc+1.
  - Opcode 4 (JMP): target = operand.
  - Opcode 5 (JZ): target = operand if zero=1, else pc+1.
  - Opcode 6 (JNZ): target = operand if zero=0, else pc+1.
  - Opcode F (HALT): go to HALT. No PC load and no ACC load.
  - Opcodes 7–E: treated as NOP.
  - All other opcodes go to EXEC.
- EXEC:
  - PCload=1 and PC_in=target for one cycle.
  - For LDI, ADD and SUB: ACCload=1, with ALUop = 00, 01 and 10 respectively.
  - Next state: FETCH if run=1 and the single-step flag is clear; otherwise IDLE. The single-step flag clears in EXEC.
- HALT:
  - halted=1. All strobes are 0.
  - run and step are ignored. The only exit is reset.
- Arithmetic:
  - pc+1 is computed modulo 2^ADDR_W, so 15 wraps to 0 when ADDR_W=4.
  - The operand is zero-extended or truncated to ADDR_W.

## Timing
- All outputs are registered, so they change only after the rising edge of clk or on reset assertion.
  - This keeps PCload and PC_in stable across the falling edge on which the PC register samples.
- Reset assertion (any cycle, including mid-instruction):
  - Immediately: state=INIT, PCload=0, PC_in=0, IRload=0, ACCload=0, ALUop=00, halted=0.
  - Internal latched opcode, operand, target and the single-step flag are cleared.
- After reset release:
  - The first rising edge shows INIT outputs, with PCload=1 for one cycle.
  - The next edge moves to IDLE.
- Latency from run (or step) sampled high in IDLE to PCload: 3 cycles (FETCH, DECODE, EXEC).
- Free-run throughput: one instruction per 3 cycles, with PCload asserted every third cycle.
- Per-instruction strobes:
  - IRload and PCload are each asserted exactly once per executed instruction.
  - ACCload is asserted at most once.
  - IRload and PCload are never high in the same cycle.
- run deasserted mid-instruction: the current instruction completes through EXEC, then the controller returns to IDLE.
- step pulses outside IDLE are ignored.

## Test plan
- Reset then INIT:
  - Stimulus: hold reset=0, then release with RESET_VEC=0.
  - Required: one cycle of PCload=1 with PC_in=0, then state=IDLE. Every output is 0 while reset=0.
- Free-run arithmetic:
  - Stimulus: program 0:LDI 3, 1:ADD 2, 2:SUB 5, with run=1.
  - Required: ALUop sequence 00, 01, 10 with ACCload in each EXEC. PC_in sequence 1, 2, 3. PCload period of 3 cycles.
- Conditional branches:
  - Stimulus: JZ 9 with zero=1 at pc=4; JNZ 9 with zero=1 at pc=4.
  - Required: the first gives PC_in=9; the second gives PC_in=5.
- Wrap-around:
  - Stimulus: NOP at pc=15.
  - Required: PC_in=0 with PCload=1.
- Single step and HALT:
  - Stimulus: run=0 with a one-cycle step pulse.
  - Required: exactly one PCload, then IDLE.
  - Stimulus: HALT opcode.
  - Required: halted=1, no PCload, and run=1 is ignored for 20 cycles.
- Mid-operation reset:
  - Stimulus: assert reset=0 during DECODE of a JMP.
  - Required: no PCload to the JMP target. After release, INIT reloads RESET_VEC.
